// File: rtl/sensor_frame_pkg.sv
// Shared constants and pointer helper for the sensor frame arbiter.
// Optional feature macro: SENSOR_FRAME_ARBITER_SEQ_TAG_EN (per-sensor sequence tags).
package sensor_frame_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SEQ_W  = 8;

    // Round-robin pointer advance with wrap at num-1.
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] ptr,
                                                 input int unsigned      num);
        if (32'(ptr) + 32'd1 >= num) begin
            return '0;
        end
        return ptr + IDX_W'(1);
    endfunction

endpackage

// File: rtl/sensor_frame_arbiter_if.sv
// Sample-capture and output-stream bundle of the sensor frame arbiter.
// m_seq_o exists only when SENSOR_FRAME_ARBITER_SEQ_TAG_EN is defined.
interface sensor_frame_arbiter_if #(
    parameter int unsigned SENSOR_NUM = 25
);
    import sensor_frame_pkg::*;

    logic [SENSOR_NUM-1:0]        wr_en_i;
    logic [SENSOR_NUM*DATA_W-1:0] wr_din_i;
    logic                         m_valid_o;
    logic                         m_ready_i;
    logic [DATA_W-1:0]            m_data_o;
    logic [IDX_W-1:0]             m_idx_o;
    logic                         m_last_o;
    logic [SENSOR_NUM-1:0]        ovf_o;
    logic                         ovf_clr_i;
`ifdef SENSOR_FRAME_ARBITER_SEQ_TAG_EN
    logic [SEQ_W-1:0]             m_seq_o;
`endif

    modport slave (
        input  wr_en_i, wr_din_i, m_ready_i, ovf_clr_i,
        output m_valid_o, m_data_o, m_idx_o, m_last_o, ovf_o
`ifdef SENSOR_FRAME_ARBITER_SEQ_TAG_EN
        , m_seq_o
`endif
    );

    modport master (
        output wr_en_i, wr_din_i, m_ready_i, ovf_clr_i,
        input  m_valid_o, m_data_o, m_idx_o, m_last_o, ovf_o
`ifdef SENSOR_FRAME_ARBITER_SEQ_TAG_EN
        , m_seq_o
`endif
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above i_ptr, wrapping to 0.
module rr_arbiter
    import sensor_frame_pkg::*;
#(
    parameter int unsigned SENSOR_NUM = 25
) (
    input  logic [SENSOR_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]      i_ptr,
    output logic                  o_gnt_vld,
    output logic [IDX_W-1:0]      o_gnt_idx
);

    int unsigned      w_pos;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_idx = '0;
        w_pos     = 0;
        w_sel     = '0;
        for (int unsigned off = 0; off < SENSOR_NUM; off++) begin
            w_pos = 32'(i_ptr) + off;
            if (w_pos >= SENSOR_NUM) begin
                w_pos = w_pos - SENSOR_NUM;
            end
            w_sel = IDX_W'(w_pos);
            if (!o_gnt_vld && i_req[w_sel]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = w_sel;
            end
        end
    end

endmodule

// File: rtl/sensor_frame_arbiter.sv
// Serialises per-sensor sample strobes onto one valid/ready stream, round-robin, with overwrite flags.
// Define SENSOR_FRAME_ARBITER_SEQ_TAG_EN to add per-sensor 8-bit sequence tags on m_seq_o.
module sensor_frame_arbiter
    import sensor_frame_pkg::*;
#(
    parameter int unsigned SENSOR_NUM = 25
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_n_i,
    sensor_frame_arbiter_if.slave bus
);

    logic [DATA_W-1:0]     r_hold [SENSOR_NUM];
    logic [SENSOR_NUM-1:0] r_pend;
    logic [SENSOR_NUM-1:0] r_ovf;
    logic [IDX_W-1:0]      r_ptr;
    logic                  r_valid;
    logic [DATA_W-1:0]     r_data;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_last;

    logic                  w_free;
    logic                  w_gnt_vld;
    logic                  w_grant;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [SENSOR_NUM-1:0] w_gnt_vec;
    logic [SENSOR_NUM-1:0] w_pend_left;

    assign w_free      = !r_valid || bus.m_ready_i;
    assign w_grant     = w_free && w_gnt_vld;
    assign w_gnt_vec   = w_grant ? (SENSOR_NUM'(1) << w_gnt_idx) : '0;
    assign w_pend_left = r_pend & ~w_gnt_vec;

    rr_arbiter #(
        .SENSOR_NUM (SENSOR_NUM)
    ) u_rr_arbiter (
        .i_req     (r_pend),
        .i_ptr     (r_ptr),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    // Holding registers: a sensor being granted this cycle may re-strobe without flagging overflow.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pend <= '0;
            r_ovf  <= '0;
            for (int unsigned k = 0; k < SENSOR_NUM; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            r_pend <= w_pend_left | bus.wr_en_i;
            r_ovf  <= (bus.ovf_clr_i ? '0 : r_ovf) | (bus.wr_en_i & w_pend_left);
            for (int unsigned k = 0; k < SENSOR_NUM; k++) begin
                if (bus.wr_en_i[k]) begin
                    r_hold[k] <= bus.wr_din_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Single output stage; loads only when empty or being drained.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_ptr   <= '0;
        end else if (w_free) begin
            if (w_gnt_vld) begin
                r_valid <= 1'b1;
                r_data  <= r_hold[w_gnt_idx];
                r_idx   <= w_gnt_idx;
                r_last  <= (w_pend_left == '0) && (bus.wr_en_i == '0);
                r_ptr   <= ptr_inc(w_gnt_idx, SENSOR_NUM);
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.m_valid_o = r_valid;
    assign bus.m_data_o  = r_data;
    assign bus.m_idx_o   = r_idx;
    assign bus.m_last_o  = r_last;
    assign bus.ovf_o     = r_ovf;

`ifdef SENSOR_FRAME_ARBITER_SEQ_TAG_EN
    logic [SEQ_W-1:0] r_seq_cnt  [SENSOR_NUM];
    logic [SEQ_W-1:0] r_hold_seq [SENSOR_NUM];
    logic [SEQ_W-1:0] r_seq;

    // Tag each sample with the count of strobes seen before it on that sensor.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_seq <= '0;
            for (int unsigned k = 0; k < SENSOR_NUM; k++) begin
                r_seq_cnt[k]  <= '0;
                r_hold_seq[k] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_seq <= r_hold_seq[w_gnt_idx];
            end
            for (int unsigned k = 0; k < SENSOR_NUM; k++) begin
                if (bus.wr_en_i[k]) begin
                    r_hold_seq[k] <= r_seq_cnt[k];
                    r_seq_cnt[k]  <= r_seq_cnt[k] + SEQ_W'(1);
                end
            end
        end
    end

    assign bus.m_seq_o = r_seq;
`endif

endmodule

// File: tb/tb_sensor_frame_arbiter.sv
// Self-checking bench for sensor_frame_arbiter: directed table, corner sequences, random vs. model.
// Seq-tag checks compile in when SENSOR_FRAME_ARBITER_SEQ_TAG_EN is defined.
`timescale 1ns/1ps
module tb_sensor_frame_arbiter;
    import sensor_frame_pkg::*;

    localparam int unsigned N  = 25;
    localparam int unsigned DW = N*DATA_W;

    logic sys_clk_i = 1'b0;
    logic rst_n_i;
    always #5 sys_clk_i = ~sys_clk_i;

    sensor_frame_arbiter_if #(.SENSOR_NUM(N)) bus ();

    sensor_frame_arbiter #(.SENSOR_NUM(N)) dut (
        .sys_clk_i (sys_clk_i),
        .rst_n_i   (rst_n_i),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_pend [N];
    int m_hold [N];
    int m_hseq [N];
    int m_scnt [N];
    bit m_ovf  [N];
    int m_ptr;
    bit m_valid;
    int m_data;
    int m_idx;
    bit m_last;
    int m_seq;

    // Log of beats accepted by downstream (DUT values)
    int q_idx  [$];
    int q_data [$];
    bit q_last [$];

    typedef struct {
        logic [N-1:0] we;
        logic [15:0]  din;
        bit           rdy;
        bit           clr;
        bit           ev;
        int           ei;
        logic [15:0]  ed;
        bit           el;
        logic [N-1:0] eo;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_ovf();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_ovf[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 0; m_hold[k] = 0; m_hseq[k] = 0; m_scnt[k] = 0; m_ovf[k] = 0;
        end
        m_ptr = 0; m_valid = 0; m_data = 0; m_idx = 0; m_last = 0; m_seq = 0;
    endtask

    task automatic model_step(input logic [N-1:0] we, input logic [DW-1:0] din,
                              input bit rdy, input bit clr);
        bit free;
        bit busy;
        int g;
        int k;
        free = !m_valid || rdy;
        g = -1;
        if (free) begin
            for (int off = 0; off < N; off++) begin
                k = (m_ptr + off) % N;
                if (g < 0 && m_pend[k]) g = k;
            end
        end
        if (g >= 0) begin
            m_valid = 1; m_data = m_hold[g]; m_idx = g; m_seq = m_hseq[g];
            m_pend[g] = 0;
            m_ptr = (g + 1) % N;
            busy = 0;
            for (int j = 0; j < N; j++) if (m_pend[j] || we[j]) busy = 1;
            m_last = !busy;
        end else if (free) begin
            m_valid = 0;
        end
        if (clr) for (int j = 0; j < N; j++) m_ovf[j] = 0;
        for (int j = 0; j < N; j++) begin
            if (we[j]) begin
                if (m_pend[j]) m_ovf[j] = 1;
                m_pend[j] = 1;
                m_hold[j] = int'(din[j*DATA_W +: DATA_W]);
                m_hseq[j] = m_scnt[j];
                m_scnt[j] = (m_scnt[j] + 1) % 256;
            end
        end
    endtask

    task automatic compare_model();
        chk("valid", 32'(bus.m_valid_o), 32'(m_valid));
        if (m_valid) begin
            chk("idx",  32'(bus.m_idx_o),  m_idx);
            chk("data", 32'(bus.m_data_o), m_data);
            chk("last", 32'(bus.m_last_o), 32'(m_last));
`ifdef SENSOR_FRAME_ARBITER_SEQ_TAG_EN
            chk("seq",  32'(bus.m_seq_o),  m_seq);
`endif
        end
        chk("ovf", 32'(bus.ovf_o), 32'(model_ovf()));
    endtask

    // Called at a negedge: drive, log accepted beat, advance model, check after the edge.
    task automatic step(input logic [N-1:0] we, input logic [DW-1:0] din,
                        input bit rdy, input bit clr);
        bus.wr_en_i   = we;
        bus.wr_din_i  = din;
        bus.m_ready_i = rdy;
        bus.ovf_clr_i = clr;
        if (bus.m_valid_o && rdy) begin
            q_idx.push_back(int'(bus.m_idx_o));
            q_data.push_back(int'(bus.m_data_o));
            q_last.push_back(bus.m_last_o);
        end
        model_step(we, din, rdy, clr);
        @(posedge sys_clk_i);
        #1;
        compare_model();
        @(negedge sys_clk_i);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step('0, '0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n_i       = 1'b0;
        bus.wr_en_i   = '0;
        bus.wr_din_i  = '0;
        bus.m_ready_i = 1'b0;
        bus.ovf_clr_i = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic clear_log();
        q_idx.delete(); q_data.delete(); q_last.delete();
    endtask

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = 16'(16'h0100 + k);
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_din();
        logic [DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = 16'($urandom);
        return r;
    endfunction

    task automatic check_burst_log(input string tag);
        chk({tag, "_count"}, q_idx.size(), N);
        for (int i = 0; i < N && i < q_idx.size(); i++) begin
            chk({tag, "_idx"},  q_idx[i],  i);
            chk({tag, "_data"}, q_data[i], 32'h100 + i);
            chk({tag, "_last"}, 32'(q_last[i]), 32'(i == N - 1));
        end
        chk({tag, "_ovf"}, 32'(bus.ovf_o), 0);
    endtask

    initial begin
        logic [N-1:0] pair;
        logic [N-1:0] six;
        int           alt_bad;
        logic [N-1:0] we;

        tbl[0]  = '{25'h0000008, 16'h1234, 1, 0, 0, 0, 16'h0000, 0, 25'h0000000};
        tbl[1]  = '{25'h0000000, 16'h0000, 1, 0, 1, 3, 16'h1234, 1, 25'h0000000};
        tbl[2]  = '{25'h0000000, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 25'h0000000};
        tbl[3]  = '{25'h0000002, 16'h0011, 0, 0, 0, 0, 16'h0000, 0, 25'h0000000};
        tbl[4]  = '{25'h0000080, 16'hAAAA, 0, 0, 1, 1, 16'h0011, 0, 25'h0000000};
        tbl[5]  = '{25'h0000080, 16'hBBBB, 0, 0, 1, 1, 16'h0011, 0, 25'h0000080};
        tbl[6]  = '{25'h0000000, 16'h0000, 1, 0, 1, 7, 16'hBBBB, 1, 25'h0000080};
        tbl[7]  = '{25'h0000000, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 25'h0000000};
        tbl[8]  = '{25'h0000080, 16'h0C0C, 0, 0, 0, 0, 16'h0000, 0, 25'h0000000};
        tbl[9]  = '{25'h0000080, 16'h0D0D, 0, 1, 1, 7, 16'h0C0C, 0, 25'h0000000};
        tbl[10] = '{25'h0000080, 16'h0E0E, 0, 1, 1, 7, 16'h0C0C, 0, 25'h0000080};
        tbl[11] = '{25'h0000000, 16'h0000, 1, 0, 1, 7, 16'h0E0E, 1, 25'h0000080};
        tbl[12] = '{25'h0000000, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 25'h0000000};

        // Reset state
        rst_n_i       = 1'b0;
        bus.wr_en_i   = '0;
        bus.wr_din_i  = '0;
        bus.m_ready_i = 1'b0;
        bus.ovf_clr_i = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk_i);
        chk("rst_valid", 32'(bus.m_valid_o), 0);
        chk("rst_data",  32'(bus.m_data_o),  0);
        chk("rst_idx",   32'(bus.m_idx_o),   0);
        chk("rst_last",  32'(bus.m_last_o),  0);
        chk("rst_ovf",   32'(bus.ovf_o),     0);
        rst_n_i = 1'b1;

        // Directed table: single-sample latency, overwrite under stall, clear vs. new overflow
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, rep(tbl[i].din), tbl[i].rdy, tbl[i].clr);
            chk("tbl_valid", 32'(bus.m_valid_o), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_idx",  32'(bus.m_idx_o),  tbl[i].ei);
                chk("tbl_data", 32'(bus.m_data_o), 32'(tbl[i].ed));
                chk("tbl_last", 32'(bus.m_last_o), 32'(tbl[i].el));
            end
            chk("tbl_ovf", 32'(bus.ovf_o), 32'(tbl[i].eo));
        end

        // Full burst, downstream always ready
        do_reset();
        clear_log();
        step('1, ramp(), 1'b1, 1'b0);
        idle(30, 1'b1);
        check_burst_log("burst");

        // Full burst with a 10-cycle downstream stall
        do_reset();
        clear_log();
        step('1, ramp(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step('0, '0, 1'b0, 1'b0);
            chk("stall_valid", 32'(bus.m_valid_o), 1);
            chk("stall_idx",   32'(bus.m_idx_o),   0);
            chk("stall_data",  32'(bus.m_data_o),  32'h100);
        end
        idle(30, 1'b1);
        check_burst_log("stallburst");

        // Fairness between two continuously strobing sensors
        clear_log();
        pair = '0;
        pair[2]  = 1'b1;
        pair[20] = 1'b1;
        for (int i = 0; i < 40; i++) step(pair, rnd_din(), 1'b1, 1'b0);
        idle(5, 1'b1);
        alt_bad = 0;
        for (int i = 1; i < q_idx.size(); i++) begin
            if (q_idx[i] == q_idx[i-1]) alt_bad++;
            if (q_idx[i] != 2 && q_idx[i] != 20) alt_bad++;
        end
        chk("fair_alternation", alt_bad, 0);
        chk("fair_min_beats", 32'(q_idx.size() >= 40), 1);

        // Reset while a beat is held and five samples pending
        six = 25'h000003F;
        step(six, ramp(), 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(bus.m_valid_o), 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.m_valid_o), 0);
        chk("mid_rst_data",  32'(bus.m_data_o),  0);
        chk("mid_rst_idx",   32'(bus.m_idx_o),   0);
        chk("mid_rst_last",  32'(bus.m_last_o),  0);
        chk("mid_rst_ovf",   32'(bus.ovf_o),     0);
        model_reset();
        repeat (2) @(negedge sys_clk_i);
        rst_n_i = 1'b1;
        clear_log();
        idle(10, 1'b1);
        chk("post_rst_no_beats", q_idx.size(), 0);

`ifdef SENSOR_FRAME_ARBITER_SEQ_TAG_EN
        // Sequence tag wrap on sensor 0
        begin
            bit wrap_seen;
            int prev_seq;
            wrap_seen = 0;
            prev_seq  = -1;
            do_reset();
            for (int i = 0; i < 300; i++) begin
                step(25'h0000001, rnd_din(), 1'b1, 1'b0);
                if (bus.m_valid_o) begin
                    if (prev_seq == 255 && bus.m_seq_o == 8'd0) wrap_seen = 1;
                    prev_seq = int'(bus.m_seq_o);
                end
            end
            idle(3, 1'b1);
            chk("seq_wrap_seen", 32'(wrap_seen), 1);
        end
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            we = N'($urandom & $urandom & $urandom);
            if ((i % 500) > 450) we = '0;
            step(we, rnd_din(), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        idle(40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
